// File: rtl/fmadd_mul_round_stage.sv
// FMADD rounding stage: rounds the post-normalized 48-bit product mantissa and packs an IEEE-754 result.
// Two-stage valid/ready pipeline; define FMADD_RND_FLAGS_EN to add the out_flags {NV,DZ,OF,UF,NX} port.
module fmadd_mul_round_stage #(
    parameter int std  = 31,
    parameter int man  = 22,
    parameter int exp  = 7,
    parameter int bias = 127
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [man+man+exp+6:0]     in_no,
    input  logic                       in_sticky,
    input  logic                       in_zero_unrounded,
    input  logic [2:0]                 in_rm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [std:0]               out_result
`ifdef FMADD_RND_FLAGS_EN
    ,
    output logic [4:0]                 out_flags
`endif
);

    localparam int EW   = exp + 2;       // incoming biased exponent width
    localparam int MW   = 2*man + 4;     // incoming mantissa width, hidden bit at MW-1
    localparam int KW   = man + 2;       // kept bits including hidden bit
    localparam int FW   = man + 1;       // packed fraction width
    localparam int EMAX = 2*bias + 1;    // all-ones exponent (inf/nan)

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    // Handshake: a word moves across a boundary only in a cycle where its valid and ready
    // are both high; ready never depends on the valid of the same boundary.
    logic adv1;
    logic s1_valid;
    assign adv1     = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv1;

    logic          in_sign;
    logic [EW-1:0] in_e;
    logic [MW-1:0] in_m;
    assign {in_sign, in_e, in_m} = in_no;

    logic [KW-1:0] kept;
    logic          guard, st, inexact, inc;
    logic [2:0]    rm_eff;

    always_comb begin
        kept    = in_m[MW-1 -: KW];
        guard   = in_m[MW-KW-1];
        st      = (|in_m[MW-KW-2:0]) | in_sticky;
        inexact = guard | st;
        rm_eff  = (in_rm > RMM) ? RNE : in_rm;
        case (rm_eff)
            RTZ:     inc = 1'b0;
            RDN:     inc = in_sign & inexact;
            RUP:     inc = !in_sign & inexact;
            RMM:     inc = guard;
            default: inc = guard & (st | kept[0]);
        endcase
    end

    logic          s1_sign, s1_inc, s1_inexact, s1_zero;
    logic [EW-1:0] s1_e;
    logic [KW-1:0] s1_kept;
    logic [2:0]    s1_rm;

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_sign    <= in_sign;
            s1_e       <= in_e;
            s1_kept    <= kept;
            s1_inc     <= inc;
            s1_inexact <= inexact;
            s1_rm      <= rm_eff;
            s1_zero    <= in_zero_unrounded;
        end
    end

    logic [KW:0]    sum;
    logic [EW:0]    e_fin;
    logic [FW-1:0]  frac;
    logic           ovf, of_f, nx_f, uf_f;
    logic [std:0]   res;

    always_comb begin
        sum   = {1'b0, s1_kept} + {{KW{1'b0}}, s1_inc};
        e_fin = {1'b0, s1_e};
        frac  = sum[FW-1:0];
        if (sum[KW]) begin
            frac  = sum[KW-1:1];
            e_fin = e_fin + (EW+1)'(1);
        end else if (s1_e == '0 && sum[KW-1]) begin
            e_fin = (EW+1)'(1);
        end
        ovf = e_fin >= (EW+1)'(EMAX);
        res = {s1_sign, e_fin[exp:0], frac};
        of_f = 1'b0;
        if (s1_zero) begin
            if (s1_inexact && ((s1_rm == RUP && !s1_sign) || (s1_rm == RDN && s1_sign)))
                res = {s1_sign, {(std-1){1'b0}}, 1'b1};
            else
                res = {s1_sign, {std{1'b0}}};
        end else if (ovf) begin
            of_f = 1'b1;
            // Directed modes saturate to max finite when rounding toward zero for that sign.
            if (s1_rm == RTZ || (s1_rm == RDN && !s1_sign) || (s1_rm == RUP && s1_sign))
                res = {s1_sign, (exp+1)'(EMAX-1), {FW{1'b1}}};
            else
                res = {s1_sign, {(exp+1){1'b1}}, {FW{1'b0}}};
        end
        nx_f = s1_inexact | of_f;
        uf_f = (res[std-1 -: exp+1] == '0) & nx_f;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
`ifdef FMADD_RND_FLAGS_EN
            out_flags  <= '0;
`endif
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (adv1)
                out_valid <= s1_valid;
            if (adv1 && s1_valid) begin
                out_result <= res;
`ifdef FMADD_RND_FLAGS_EN
                out_flags  <= {2'b00, of_f, uf_f, nx_f};
`endif
            end
        end
    end

endmodule

// File: tb/tb_fmadd_mul_round_stage.sv
// Directed-vector bench for fmadd_mul_round_stage with an expected-queue scoreboard.
// Flags are compared only when FMADD_RND_FLAGS_EN is defined.
module tb_fmadd_mul_round_stage;

  localparam int W = 37;  // {flags[4:0], result[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [57:0] in_no;
  logic        in_sticky;
  logic        in_zero_unrounded;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FMADD_RND_FLAGS_EN
  logic [4:0]  out_flags;
`endif

  fmadd_mul_round_stage dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_no(in_no),
    .in_sticky(in_sticky),
    .in_zero_unrounded(in_zero_unrounded),
    .in_rm(in_rm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result)
`ifdef FMADD_RND_FLAGS_EN
    ,
    .out_flags(out_flags)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // driver: present one word, push its expected response when the transfer is certain
  task automatic send(input logic s, input logic [8:0] e, input logic [47:0] m,
                      input logic stk, input logic zu, input logic [2:0] rm,
                      input logic [31:0] res, input logic [4:0] fl);
    int n;
    n = 0;
    in_no = {s, e, m};
    in_sticky = stk;
    in_zero_unrounded = zu;
    in_rm = rm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end else begin
      exp_q.push_back({fl, res});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d words still pending, required 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h, required no output", out_result);
      end else begin
        e = exp_q.pop_front();
        check("result", out_result, e[31:0]);
`ifdef FMADD_RND_FLAGS_EN
        check("flags", out_flags, e[36:32]);
`endif
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_no = '0;
    in_sticky = 1'b0;
    in_zero_unrounded = 1'b0;
    in_rm = 3'b000;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_result", out_result, 32'h0);
`ifdef FMADD_RND_FLAGS_EN
    check("reset_out_flags", out_flags, 5'h0);
`endif
    @(posedge clk);
    #1;

    // directed vectors, out_ready held high
    send(1'b0, 9'd127, 48'h800000_000000, 1'b0, 1'b0, 3'b000, 32'h3F800000, 5'h00);
    send(1'b0, 9'd127, 48'h800001_800000, 1'b0, 1'b0, 3'b000, 32'h3F800002, 5'h01);
    send(1'b0, 9'd127, 48'h800001_800000, 1'b0, 1'b0, 3'b001, 32'h3F800001, 5'h01);
    send(1'b0, 9'd127, 48'h800001_800000, 1'b0, 1'b0, 3'b111, 32'h3F800002, 5'h01);
    send(1'b0, 9'd255, 48'h800000_000000, 1'b0, 1'b0, 3'b000, 32'h7F800000, 5'h05);
    send(1'b0, 9'd255, 48'h800000_000000, 1'b0, 1'b0, 3'b001, 32'h7F7FFFFF, 5'h05);
    send(1'b1, 9'd255, 48'h800000_000000, 1'b0, 1'b0, 3'b011, 32'hFF7FFFFF, 5'h05);
    send(1'b1, 9'd255, 48'h800000_000000, 1'b0, 1'b0, 3'b010, 32'hFF800000, 5'h05);
    send(1'b0, 9'd300, 48'h800000_000000, 1'b0, 1'b0, 3'b010, 32'h7F7FFFFF, 5'h05);
    send(1'b0, 9'd0,   48'h7FFFFF_800000, 1'b0, 1'b0, 3'b000, 32'h00800000, 5'h01);
    send(1'b0, 9'd0,   48'h000000_000000, 1'b1, 1'b1, 3'b011, 32'h00000001, 5'h03);
    send(1'b1, 9'd0,   48'h000000_000000, 1'b1, 1'b1, 3'b000, 32'h80000000, 5'h03);
    send(1'b1, 9'd0,   48'h000000_000000, 1'b1, 1'b1, 3'b010, 32'h80000001, 5'h03);
    send(1'b1, 9'd0,   48'h000000_000000, 1'b0, 1'b1, 3'b011, 32'h80000000, 5'h00);
    drain("drain_directed");

    // backpressure: two words fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    send(1'b1, 9'd127, 48'h800000_000001, 1'b0, 1'b0, 3'b010, 32'hBF800001, 5'h01);
    send(1'b0, 9'd130, 48'hC00000_800000, 1'b0, 1'b0, 3'b100, 32'h41400001, 5'h01);
    @(negedge clk);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        send(1'b0, 9'd127, 48'hFFFFFF_800000, 1'b0, 1'b0, 3'b000, 32'h40000000, 5'h01);
        send(1'b0, 9'd254, 48'hFFFFFF_FFFFFF, 1'b0, 1'b0, 3'b011, 32'h7F800000, 5'h05);
      end
    join
    drain("drain_backpressure");

    // reset during a stall discards in-flight words
    out_ready = 1'b0;
    send(1'b0, 9'd127, 48'h800000_000000, 1'b0, 1'b0, 3'b000, 32'h3F800000, 5'h00);
    send(1'b1, 9'd127, 48'h800000_000000, 1'b0, 1'b0, 3'b000, 32'hBF800000, 5'h00);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall_out_valid", out_valid, 1'b0);
    check("rst_stall_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(1'b0, 9'd128, 48'h800000_800000, 1'b0, 1'b0, 3'b000, 32'h40000000, 5'h01);
    drain("drain_after_reset");
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
